// File: rtl/alu_bist_engine.sv
// -----------------------------------------------------------------------------
// alu_bist_engine
//
// Built-in self-test initiator for the datapath ALU. While a test runs it owns
// the ALU inputs: two Galois LFSRs supply operands A and B and a function
// counter sweeps codes 0..NUM_FUNCS-1, applying NUM_VECTORS operand pairs per
// code. Every ALU result is folded into a 32-bit MISR signature and the zero
// flag is cross-checked against the result. On completion the signature is
// compared with a supplied golden value to produce pass/fail.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset (wins over start)
//   start           launch a test; honoured only in IDLE and DONE
//   golden_sig      expected final signature, compared on DONE entry
//   alu_result      ALU result (combinational from alu_a/alu_b/alu_function)
//   alu_zero        ALU zero flag
//   alu_a, alu_b    registered operands driven to the ALU
//   alu_function    registered 4-bit function code driven to the ALU
//   busy            high while the sweep is running
//   done            high while the finished result is being held
//   pass            signature match and no zero-flag errors; valid with done
//   signature       current MISR value
//   zero_err_count  zero-flag mismatches seen, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module alu_bist_engine #(
  parameter int          NUM_VECTORS = 16,
  parameter int          NUM_FUNCS   = 10,
  parameter logic [31:0] SEED_A      = 32'h0000_0001,
  parameter logic [31:0] SEED_B      = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] golden_sig,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_function,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature,
  output logic [15:0] zero_err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  // An all-zero LFSR never leaves zero, so a zero seed is promoted to 1.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  localparam int              VEC_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);
  localparam logic [3:0]      FUNC_LAST = 4'(NUM_FUNCS - 1);

  logic [1:0]       state;
  logic [VEC_W-1:0] vec_cnt;
  logic [31:0]      sig_next;
  logic [15:0]      zerr_next;
  logic             zero_mismatch;
  logic             last_vec;
  logic             last_func;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_POLY : 32'h0);
  endfunction

  // Next-state values for the compressor and the flag checker; they are used
  // both for the register update and for the pass decision on DONE entry, so
  // pass reflects the final vector as well.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sig_next      = {signature[30:0], 1'b0} ^ (signature[31] ? MISR_POLY : 32'h0) ^ alu_result;
    zero_mismatch = alu_zero != (alu_result == 32'h0);
    zerr_next     = zero_err_count;
    if (zero_mismatch && (zero_err_count != 16'hFFFF)) begin
      zerr_next = zero_err_count + 16'd1;
    end
    last_vec  = (vec_cnt == VEC_LAST);
    last_func = (alu_function == FUNC_LAST);
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      alu_a          <= 32'h0;
      alu_b          <= 32'h0;
      alu_function   <= 4'h0;
      vec_cnt        <= '0;
      signature      <= 32'h0;
      zero_err_count <= 16'h0;
      pass           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // Restart from DONE is identical to a launch from IDLE.
          if (start) begin
            state          <= ST_RUN;
            alu_a          <= SEED_A_EFF;
            alu_b          <= SEED_B_EFF;
            alu_function   <= 4'h0;
            vec_cnt        <= '0;
            signature      <= 32'h0;
            zero_err_count <= 16'h0;
            pass           <= 1'b0;
          end
        end

        ST_RUN: begin
          // The vector on alu_a/alu_b has been held a full cycle; its result
          // is absorbed at this closing edge. start is ignored here.
          signature      <= sig_next;
          zero_err_count <= zerr_next;
          if (last_vec && last_func) begin
            state        <= ST_DONE;
            alu_a        <= 32'h0;
            alu_b        <= 32'h0;
            alu_function <= 4'h0;
            vec_cnt      <= '0;
            pass         <= (sig_next == golden_sig) && (zerr_next == 16'h0);
          end else begin
            // Operand LFSRs free-run across function boundaries.
            alu_a <= lfsr_step(alu_a);
            alu_b <= lfsr_step(alu_b);
            if (last_vec) begin
              vec_cnt      <= '0;
              alu_function <= alu_function + 4'd1;
            end else begin
              vec_cnt <= vec_cnt + 1'b1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_engine.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_engine
//
// Self-checking bench for alu_bist_engine (NUM_VECTORS=4, NUM_FUNCS=10).
// A behavioural ALU sits beside the engine; optional faults can invert the
// zero flag or force result bit 5 high. A reference model precomputes the
// operand sequence and the final signature from the LFSR/MISR rules.
// -----------------------------------------------------------------------------
module tb_alu_bist_engine;

  localparam int          NV        = 4;
  localparam int          NF        = 10;
  localparam int          TOTAL     = NV * NF;
  localparam logic [31:0] SEED_A    = 32'h0000_0001;
  localparam logic [31:0] SEED_B    = 32'hACE1_2468;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] golden_sig;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_function;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] signature;
  logic [15:0] zero_err_count;

  logic        flip_zero;
  logic        stuck5;
  logic [31:0] true_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_a [TOTAL];
  logic [31:0] exp_b [TOTAL];
  logic [3:0]  exp_f [TOTAL];
  logic [31:0] model_sig;

  always #5 clk = ~clk;

  alu_bist_engine #(
    .NUM_VECTORS(NV),
    .NUM_FUNCS  (NF),
    .SEED_A     (SEED_A),
    .SEED_B     (SEED_B)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .golden_sig    (golden_sig),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_function  (alu_function),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .zero_err_count(zero_err_count)
  );

  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return $signed(a) >>> b[4:0];
      4'd9:    return {31'b0, $signed(a) < $signed(b)};
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural ALU with fault hooks.
  always_comb true_result = alu_ref(alu_function, alu_a, alu_b);
  assign alu_result = stuck5 ? (true_result | 32'h20) : true_result;
  assign alu_zero   = (alu_result == 32'h0) ^ flip_zero;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a"},    alu_a, 32'h0);
    check({tag, "_b"},    alu_b, 32'h0);
    check({tag, "_f"},    {28'h0, alu_function}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_pass"}, {31'h0, pass}, 32'h0);
    check({tag, "_sig"},  signature, 32'h0);
    check({tag, "_zec"},  {16'h0, zero_err_count}, 32'h0);
  endtask

  // Launch one test and follow it to DONE entry, comparing every applied
  // vector with the model. flip_at >= 0 inverts alu_zero for three vectors.
  task automatic run_test(input logic [31:0] g, input bit hold, input int flip_at,
                          input string tag);
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clk);
    golden_sig = g;
    start      = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, "_done_drops"}, {31'h0, done}, 32'h0);
    for (int i = 0; i < TOTAL; i++) begin
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
      check({tag, "_a"},    alu_a, exp_a[i]);
      check({tag, "_b"},    alu_b, exp_b[i]);
      check({tag, "_f"},    {28'h0, alu_function}, {28'h0, exp_f[i]});
      if (busy) busy_cycles++;
      flip_zero = (flip_at >= 0) && (i >= flip_at) && (i < flip_at + 3);
      @(negedge clk);
    end
    flip_zero = 1'b0;
    start     = 1'b0;
    check({tag, "_busy_cycles"}, busy_cycles, TOTAL);
    check({tag, "_done"},   {31'h0, done}, 32'h1);
    check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
    check({tag, "_a_end"},  alu_a, 32'h0);
    check({tag, "_b_end"},  alu_b, 32'h0);
    check({tag, "_f_end"},  {28'h0, alu_function}, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b, sig, r;
    int          flip_at;
    int          wait_n;

    // Reference model: operand sequence and final signature from the rules.
    a   = SEED_A;
    b   = SEED_B;
    sig = 32'h0;
    for (int f = 0; f < NF; f++) begin
      for (int v = 0; v < NV; v++) begin
        exp_a[f*NV+v] = a;
        exp_b[f*NV+v] = b;
        exp_f[f*NV+v] = 4'(f);
        r   = alu_ref(4'(f), a, b);
        sig = {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ r;
        a   = (a >> 1) ^ (a[0] ? LFSR_POLY : 32'h0);
        b   = (b >> 1) ^ (b[0] ? LFSR_POLY : 32'h0);
      end
    end
    model_sig = sig;

    reset      = 1'b1;
    start      = 1'b1;
    golden_sig = 32'h0;
    flip_zero  = 1'b0;
    stuck5     = 1'b0;

    // Reset held two cycles with start high: no RUN entry.
    @(negedge clk);
    check("rst_busy_during", {31'h0, busy}, 32'h0);
    @(negedge clk);
    check("rst_busy_during2", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");

    // Golden match against the model.
    run_test(model_sig, 1'b0, -1, "golden");
    check("golden_sig",  signature, model_sig);
    check("golden_zec",  {16'h0, zero_err_count}, 32'h0);
    check("golden_pass", {31'h0, pass}, 32'h1);

    // DONE holds without start.
    wait_n = int'($urandom_range(3, 10));
    repeat (wait_n) @(negedge clk);
    check("hold_done", {31'h0, done}, 32'h1);
    check("hold_sig",  signature, model_sig);
    check("hold_pass", {31'h0, pass}, 32'h1);

    // Restart from DONE with a wrong golden value.
    run_test(model_sig ^ 32'h1, 1'b0, -1, "badgold");
    check("badgold_sig",  signature, model_sig);
    check("badgold_pass", {31'h0, pass}, 32'h0);

    // Zero flag inverted for three vectors at a random point.
    flip_at = int'($urandom_range(0, TOTAL - 3));
    run_test(model_sig, 1'b0, flip_at, "zflip");
    check("zflip_zec",  {16'h0, zero_err_count}, 32'h3);
    check("zflip_sig",  signature, model_sig);
    check("zflip_pass", {31'h0, pass}, 32'h0);

    // Result bit 5 stuck high.
    stuck5 = 1'b1;
    run_test(model_sig, 1'b0, -1, "stuck");
    stuck5 = 1'b0;
    checks++;
    assert (signature !== model_sig) else begin
      errors++;
      $error("FAIL stuck_sig_differs observed=%h expected_not=%h", signature, model_sig);
    end
    check("stuck_pass", {31'h0, pass}, 32'h0);

    // start held through RUN: length unchanged.
    run_test(model_sig, 1'b1, -1, "held");
    check("held_pass", {31'h0, pass}, 32'h1);

    // Reset in the middle of a run.
    @(negedge clk);
    golden_sig = model_sig;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_a_before", alu_a, exp_a[10]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midrst");
    @(negedge clk);
    check("midrst_stay_idle", {31'h0, busy}, 32'h0);

    // Fresh start reproduces vector 0 and the full sequence.
    run_test(model_sig, 1'b0, -1, "fresh");
    check("fresh_sig",  signature, model_sig);
    check("fresh_pass", {31'h0, pass}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
